// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : Load/store memory stage. Accepts one byte/halfword/word access at
//            a time, drives a single-port combinational-read data memory, and
//            returns a load result (sign- or zero-extended) or a completion
//            for stores. Sub-word stores use a read-modify-write pass.
// Revision : 1.0 - initial release
//
// Ports
//   clk          clock, rising-edge
//   reset        asynchronous active-low reset
//   req_valid    request present          req_ready   request accepted (IDLE)
//   req_store    1 store / 0 load         req_size    00 B, 01 H, 10 W, 11 rsvd
//   req_signed   load sign-extension      req_addr    byte address
//   req_wdata    right-aligned store data
//   resp_valid   response present         resp_ready  response consumed
//   resp_rdata   extended load data (0 for stores/errors)
//   resp_err     request rejected (only with LSU_MISALIGN_TRAP_EN)
//   mem_addr     word index (upper bits zero)
//   mem_we       one-cycle write strobe   mem_wdata   full write word
//   mem_rdata    combinational read word at mem_addr
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined: misaligned halfword/word and size 11 are
//                         rejected with resp_err=1 after one cycle.
//                         undefined: low address bits below the access size
//                         are ignored, size 11 acts as word, resp_err is 0.
// ============================================================================
module lsu_mem_stage #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;

  // Request fields latched at accept
  logic                 lat_store;
  logic [1:0]           lat_size;
  logic                 lat_signed;
  logic [1:0]           lat_off;
  logic [15:0]          lat_wdata;
  logic                 lat_word;

  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;

  logic                 req_bad;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [31:0]          load_val;
  logic [31:0]          merge_val;

  // Only the word-index bits and the byte offset of the address are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  logic err_q;

  assign req_bad = (req_size == SIZE_RSVD)
                 | ((req_size == SIZE_HALF) & req_addr[0])
                 | ((req_size == SIZE_WORD) & (|req_addr[1:0]));
  assign resp_err = err_q;
`else
  assign req_bad  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Size 11 only reaches ACCESS when trapping is disabled, where it is a word.
  assign lat_word = lat_size[1];

  assign mem_addr   = {{(32 - ADDR_BITS){1'b0}}, idx_q};
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // A word store writes straight away; sub-word stores must first read
        // the surrounding lanes, so they take an extra MERGE cycle.
        mem_we     = lat_store & lat_word;
        state_next = (lat_store && !lat_word) ? MERGE : RESP;
      end
      MERGE: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Lane extraction for loads and lane insertion for sub-word stores
  // --------------------------------------------------------------------------
  always_comb begin
    lane_byte = mem_rdata[{lat_off, 3'b000} +: 8];
    lane_half = mem_rdata[{lat_off[1], 4'b0000} +: 16];

    if (lat_word) begin
      load_val = mem_rdata;
    end else if (lat_size == SIZE_HALF) begin
      load_val = {{16{lat_signed & lane_half[15]}}, lane_half};
    end else begin
      load_val = {{24{lat_signed & lane_byte[7]}}, lane_byte};
    end

    merge_val = mem_rdata;
    if (lat_size == SIZE_HALF) begin
      merge_val[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
    end else begin
      merge_val[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_store  <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_off    <= 2'b00;
      lat_wdata  <= 16'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_store  <= req_store;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            // Stores and rejected requests report zero data.
            rdata_q    <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q      <= req_bad;
`endif
            // Memory-side outputs only move for requests that touch memory,
            // and write data only when a write is about to be issued.
            if (!req_bad) begin
              idx_q <= req_addr[ADDR_BITS+1:2];
              if (req_store && req_size[1]) begin
                wdata_q <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!lat_store) begin
            rdata_q <= load_val;
          end else if (!lat_word) begin
            // wdata_q doubles as the merge register for the MERGE write.
            wdata_q <= merge_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-index width driven to the data memory (2**ADDR_BITS words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents an access request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  pipeline consumes the response.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected (misaligned or reserved size).
REQ-015 mem_addr  output  32  word index to data memory; bits above ADDR_BITS-1 are 0.
REQ-016 mem_we  output  1  data-memory write enable, high exactly one cycle per performed store.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  combinational read word at mem_addr; byte lane n = bits [8n+7:8n], lane n = byte address offset n.

Function
REQ-019 FSM states IDLE, ACCESS, MERGE, RESP; one request in flight at a time.
REQ-020 IDLE: req_ready=1; on req_valid latch store, size, signed, addr, wdata; go ACCESS.
REQ-021 ACCESS: mem_addr = latched addr[ADDR_BITS+1:2]; load captures extracted lane(s) of mem_rdata, goes RESP; word store drives mem_we=1, mem_wdata=wdata, goes RESP; sub-word store captures mem_rdata into merge register, goes MERGE.
REQ-022 MERGE: mem_we=1, mem_wdata = merge register with addressed byte/halfword lane(s) replaced by wdata low bits, other lanes unchanged; go RESP.
REQ-023 RESP: resp_valid=1, outputs stable until resp_ready=1; on that edge go IDLE.
REQ-024 req_ready=0 outside IDLE; no back-to-back accept in the RESP handshake cycle.
REQ-025 Latency accept-edge to resp_valid: load 2 cycles, word store 2, sub-word store 3 (error per REQ-034).
REQ-026 Byte load selects lane addr[1:0]; halfword load selects lanes {addr[1]*2+1, addr[1]*2}; extension per req_signed.
REQ-027 mem_we=0 in IDLE, RESP and all load cycles; mem_addr/mem_wdata are don't-care but held at last value when mem_we=0.

Reset
REQ-028 reset low forces IDLE immediately, asynchronously.
REQ-029 Reset values: req_ready=1 (once reset released), resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-operation abandons the request; no mem_we pulse and no response is produced for it.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN selects misalignment handling.
REQ-032 Defined: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11 is an error.
REQ-033 Not defined: low address bits below access size ignored (halfword uses addr[1], word uses lane 0); size 11 treated as word; resp_err tied 0.
REQ-034 Error path (macro defined): IDLE goes directly to RESP with resp_err=1, resp_rdata=0, no memory write; latency 1 cycle.

Verification
REQ-035 Word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> mem_we one pulse at mem_addr 4; load resp_rdata=0xDEADBEEF, latency 2.
REQ-036 Memory word 4 = 0xDEADBEEF; byte store 0x55 to addr 0x12 -> mem_wdata=0xDE55BEEF, latency 3; signed byte load 0x12 -> 0x00000055.
REQ-037 Signed halfword load 0x12 of 0xDE55BEEF -> 0xFFFFDE55; unsigned -> 0x0000DE55; signed byte load 0x11 -> 0xFFFFFFBE.
REQ-038 resp_ready held low 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-039 Word load at addr 0x13 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, rdata=0, latency 1, no mem_we; without: returns word at index 4.
REQ-040 reset asserted during MERGE of a byte store -> mem_we never pulses, resp_valid=0, memory word unchanged, IDLE after release.
